// File: rtl/udlx_pkg.sv
// Shared uDLX definitions: memory access size encodings, MEM-stage FSM states
// and the alignment rule used by the MEM stage.
package udlx_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } ma_state_e;

  // Byte accesses are always aligned; the reserved size behaves as a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      MEM_BYTE: mis = 1'b0;
      MEM_HALF: mis = addr_lo[0];
      default:  mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/memory_access_if.sv
// Data-memory bus between the MEM stage (master) and data memory (slave).
interface memory_access_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] dmem_addr_out;
  logic [DATA_WIDTH-1:0] dmem_wr_data_out;
  logic [3:0]            dmem_byte_en_out;
  logic                  dmem_rd_en_out;
  logic                  dmem_wr_en_out;
  logic [DATA_WIDTH-1:0] dmem_rd_data_in;
  logic                  dmem_ack_in;

  modport master (
    output dmem_addr_out, dmem_wr_data_out, dmem_byte_en_out, dmem_rd_en_out, dmem_wr_en_out,
    input  dmem_rd_data_in, dmem_ack_in
  );

  modport slave (
    input  dmem_addr_out, dmem_wr_data_out, dmem_byte_en_out, dmem_rd_en_out, dmem_wr_en_out,
    output dmem_rd_data_in, dmem_ack_in
  );
endinterface

// File: rtl/load_align.sv
// Load data alignment: shift the addressed lane down, truncate to the access
// size and sign- or zero-extend.
module load_align
  import udlx_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  input  logic [1:0]            addr_i,
  input  logic [1:0]            size_i,
  input  logic                  sign_ext_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DATA_WIDTH-1:0] shifted;

  // Little-endian lane select followed by size truncation and extension.
  always_comb begin
    shifted = rd_data_i >> {addr_i, 3'b000};
    case (size_i)
      MEM_BYTE: data_o = {{(DATA_WIDTH-8){sign_ext_i & shifted[7]}}, shifted[7:0]};
      MEM_HALF: data_o = {{(DATA_WIDTH-16){sign_ext_i & shifted[15]}}, shifted[15:0]};
      default:  data_o = shifted;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// uDLX MEM stage: drives the data-memory handshake, stalls upstream while an
// access is outstanding, aligns load data and holds the MEM/WB register.
module memory_access
  import udlx_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     alu_data_in,
  input  logic [DATA_WIDTH-1:0]     store_data_in,
  input  logic                      mem_rd_en_in,
  input  logic                      mem_wr_en_in,
  input  logic [1:0]                mem_size_in,
  input  logic                      mem_sign_ext_in,
  input  logic                      reg_wr_en_in,
  input  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_in,
  input  logic                      write_back_mux_sel_in,
  memory_access_if.master           dmem,
  output logic                      stall_out,
  output logic                      misaligned_out,
  output logic [DATA_WIDTH-1:0]     mem_data_out,
  output logic [DATA_WIDTH-1:0]     alu_data_out,
  output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_out,
  output logic                      reg_wr_en_out,
  output logic                      write_back_mux_sel_out
);

  ma_state_e                 state_q;
  logic [DATA_WIDTH-1:0]     addr_q, wdata_q, mem_data_q, alu_q;
  logic [3:0]                be_q;
  logic                      rd_q, wr_q, mis_q, wen_q, wbsel_q;
  logic [REG_ADDR_WIDTH-1:0] waddr_q;

  logic                  mem_op, is_store, aligned, stall;
  logic [DATA_WIDTH-1:0] st_data_d, load_data;
  logic [3:0]            st_be_d;

  // A store wins when both request flags are set.
  assign mem_op   = mem_rd_en_in | mem_wr_en_in;
  assign is_store = mem_wr_en_in;
  assign aligned  = ~is_misaligned(mem_size_in, alu_data_in[1:0]);
  assign stall    = ((state_q == ST_IDLE) & mem_op & aligned) |
                    ((state_q == ST_ACCESS) & ~dmem.dmem_ack_in);

  // Store lane steering: replicate the operand and enable the addressed lanes.
  always_comb begin
    case (mem_size_in)
      MEM_BYTE: begin
        st_data_d = {4{store_data_in[7:0]}};
        st_be_d   = 4'b0001 << alu_data_in[1:0];
      end
      MEM_HALF: begin
        st_data_d = {2{store_data_in[15:0]}};
        st_be_d   = alu_data_in[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_data_d = store_data_in;
        st_be_d   = 4'b1111;
      end
    endcase
  end

  load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .rd_data_i  (dmem.dmem_rd_data_in),
    .addr_i     (alu_data_in[1:0]),
    .size_i     (mem_size_in),
    .sign_ext_i (mem_sign_ext_in),
    .data_o     (load_data)
  );

  // Access FSM, registered bus request and MEM/WB register; upstream inputs are
  // held stable while stalled, so the ack cycle can use them directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      mis_q      <= 1'b0;
      mem_data_q <= '0;
      alu_q      <= '0;
      waddr_q    <= '0;
      wen_q      <= 1'b0;
      wbsel_q    <= 1'b0;
    end else begin
      mis_q <= 1'b0;
      if (stall) wen_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mem_op && aligned) begin
            addr_q  <= {alu_data_in[DATA_WIDTH-1:2], 2'b00};
            wdata_q <= st_data_d;
            be_q    <= is_store ? st_be_d : 4'b1111;
            rd_q    <= ~is_store;
            wr_q    <= is_store;
            state_q <= ST_ACCESS;
          end else begin
            mem_data_q <= '0;
            alu_q      <= alu_data_in;
            waddr_q    <= reg_wr_addr_in;
            wbsel_q    <= write_back_mux_sel_in;
            wen_q      <= mem_op ? 1'b0 : reg_wr_en_in;
            mis_q      <= mem_op;
          end
        end
        ST_ACCESS: begin
          if (dmem.dmem_ack_in) begin
            mem_data_q <= is_store ? '0 : load_data;
            alu_q      <= alu_data_in;
            waddr_q    <= reg_wr_addr_in;
            wbsel_q    <= write_back_mux_sel_in;
            wen_q      <= reg_wr_en_in;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dmem.dmem_addr_out    = addr_q;
  assign dmem.dmem_wr_data_out = wdata_q;
  assign dmem.dmem_byte_en_out = be_q;
  assign dmem.dmem_rd_en_out   = rd_q;
  assign dmem.dmem_wr_en_out   = wr_q;

  assign stall_out              = stall;
  assign misaligned_out         = mis_q;
  assign mem_data_out           = mem_data_q;
  assign alu_data_out           = alu_q;
  assign reg_wr_addr_out        = waddr_q;
  assign reg_wr_en_out          = wen_q;
  assign write_back_mux_sel_out = wbsel_q;

endmodule

// File: tb/tb_memory_access.sv
// Testbench for the uDLX MEM stage: directed transactions, scoreboard of
// expected MEM/WB contents, and a monitor that compares each accepted result.
module tb_memory_access;

  logic        clk, rst;
  logic [31:0] alu_data_in, store_data_in;
  logic        mem_rd_en_in, mem_wr_en_in, mem_sign_ext_in;
  logic [1:0]  mem_size_in;
  logic        reg_wr_en_in, write_back_mux_sel_in;
  logic [4:0]  reg_wr_addr_in;
  logic        stall_out, misaligned_out;
  logic [31:0] mem_data_out, alu_data_out;
  logic [4:0]  reg_wr_addr_out;
  logic        reg_wr_en_out, write_back_mux_sel_out;

  memory_access_if #(.DATA_WIDTH(32)) bus ();

  memory_access #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .alu_data_in            (alu_data_in),
    .store_data_in          (store_data_in),
    .mem_rd_en_in           (mem_rd_en_in),
    .mem_wr_en_in           (mem_wr_en_in),
    .mem_size_in            (mem_size_in),
    .mem_sign_ext_in        (mem_sign_ext_in),
    .reg_wr_en_in           (reg_wr_en_in),
    .reg_wr_addr_in         (reg_wr_addr_in),
    .write_back_mux_sel_in  (write_back_mux_sel_in),
    .dmem                   (bus),
    .stall_out              (stall_out),
    .misaligned_out         (misaligned_out),
    .mem_data_out           (mem_data_out),
    .alu_data_out           (alu_data_out),
    .reg_wr_addr_out        (reg_wr_addr_out),
    .reg_wr_en_out          (reg_wr_en_out),
    .write_back_mux_sel_out (write_back_mux_sel_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu, store, rdata;
    logic        rd, wr;
    logic [1:0]  size;
    logic        se, wen;
    logic [4:0]  wa;
    logic        wbs;
    int          delay;
    logic [31:0] e_mem;
    logic        e_wen, e_mis;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
  } txn_t;

  typedef struct {
    logic [31:0] mem, alu;
    logic [4:0]  wa;
    logic        wen, wbs, mis;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  logic tracked = 1'b0;
  logic pend = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endfunction

  task automatic drive_nop();
    alu_data_in = '0; store_data_in = '0; mem_rd_en_in = 1'b0; mem_wr_en_in = 1'b0;
    mem_size_in = 2'b10; mem_sign_ext_in = 1'b0; reg_wr_en_in = 1'b0;
    reg_wr_addr_in = '0; write_back_mux_sel_in = 1'b0;
  endtask

  // A result is expected after every edge at which a tracked transaction was accepted.
  always @(posedge clk) pend <= !rst && tracked && !stall_out;

  // Monitor: pop and compare the MEM/WB register whenever a result is presented.
  always @(negedge clk) begin
    if (pend) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL wb_unexpected: got write-back with empty scoreboard at %0t", $time);
      end else begin
        e = sbq.pop_front();
        chk("wb_mem_data", mem_data_out, e.mem);
        chk("wb_alu_data", alu_data_out, e.alu);
        chk("wb_reg_addr", {27'd0, reg_wr_addr_out}, {27'd0, e.wa});
        chk("wb_reg_wen", {31'd0, reg_wr_en_out}, {31'd0, e.wen});
        chk("wb_mux_sel", {31'd0, write_back_mux_sel_out}, {31'd0, e.wbs});
        chk("wb_misaligned", {31'd0, misaligned_out}, {31'd0, e.mis});
      end
    end
  end

  // Issue one transaction starting just after a rising edge; returns just after
  // the edge at which it was accepted.
  task automatic run(input txn_t v);
    logic memop;
    memop = v.rd | v.wr;
    alu_data_in = v.alu; store_data_in = v.store; mem_rd_en_in = v.rd; mem_wr_en_in = v.wr;
    mem_size_in = v.size; mem_sign_ext_in = v.se; reg_wr_en_in = v.wen;
    reg_wr_addr_in = v.wa; write_back_mux_sel_in = v.wbs;
    tracked = 1'b1;
    sbq.push_back('{v.e_mem, v.alu, v.wa, v.e_wen, v.wbs, v.e_mis});
    #1;
    chk("stall_cycle0", {31'd0, stall_out}, {31'd0, memop & ~v.e_mis});
    if (memop && !v.e_mis) begin
      @(posedge clk); #2;
      chk("req_rd_en", {31'd0, bus.dmem_rd_en_out}, {31'd0, v.rd & ~v.wr});
      chk("req_wr_en", {31'd0, bus.dmem_wr_en_out}, {31'd0, v.wr});
      chk("req_addr", bus.dmem_addr_out, v.e_addr);
      chk("req_byte_en", {28'd0, bus.dmem_byte_en_out}, {28'd0, v.e_be});
      chk("req_wr_data", bus.dmem_wr_data_out, v.e_wdata);
      for (int i = 0; i < v.delay; i++) begin
        chk("stall_wait", {31'd0, stall_out}, 32'd1);
        chk("bubble_wen", {31'd0, reg_wr_en_out}, 32'd0);
        @(posedge clk); #2;
        chk("req_held_addr", bus.dmem_addr_out, v.e_addr);
        chk("req_held_en", {30'd0, bus.dmem_rd_en_out, bus.dmem_wr_en_out}, {30'd0, v.rd & ~v.wr, v.wr});
      end
      bus.dmem_rd_data_in = v.rdata;
      bus.dmem_ack_in = 1'b1;
      #1;
      chk("stall_ack", {31'd0, stall_out}, 32'd0);
      @(posedge clk); #2;
      bus.dmem_ack_in = 1'b0;
      bus.dmem_rd_data_in = '0;
      chk("req_drop", {30'd0, bus.dmem_rd_en_out, bus.dmem_wr_en_out}, 32'd0);
      tracked = 1'b0;
      drive_nop();
    end else begin
      @(posedge clk); #2;
      tracked = 1'b0;
      drive_nop();
      if (v.e_mis) begin
        chk("mis_no_req", {31'd0, bus.dmem_rd_en_out}, 32'd0);
        @(posedge clk); #2;
        chk("mis_one_pulse", {31'd0, misaligned_out}, 32'd0);
      end
    end
  endtask

  txn_t vec[12];

  initial begin
    // alu, store, rdata, rd, wr, size, se, wen, wa, wbs, delay, e_mem, e_wen, e_mis, e_addr, e_be, e_wdata
    vec[0]  = '{32'h1234, 32'h0, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 5'd3, 1'b0, 0, 32'h0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0};
    vec[1]  = '{32'h102, 32'h0, 32'h80FF7F01, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 5'd5, 1'b1, 0, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0};
    vec[2]  = '{32'h102, 32'h0, 32'h80FF7F01, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 5'd5, 1'b1, 0, 32'h000000FF, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0};
    vec[3]  = '{32'h6, 32'hABCD, 32'h0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 5'd0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 32'h4, 4'b1100, 32'hABCDABCD};
    vec[4]  = '{32'h202, 32'h0, 32'h80011234, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 5'd7, 1'b1, 3, 32'hFFFF8001, 1'b1, 1'b0, 32'h200, 4'hF, 32'h0};
    vec[5]  = '{32'h300, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd8, 1'b1, 1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h300, 4'hF, 32'h0};
    vec[6]  = '{32'h13, 32'h5A, 32'h0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 32'h10, 4'b1000, 32'h5A5A5A5A};
    vec[7]  = '{32'h1002, 32'h0, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd9, 1'b1, 0, 32'h0, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0};
    vec[8]  = '{32'h20, 32'h11223344, 32'hFFFFFFFF, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 5'd0, 1'b0, 2, 32'h0, 1'b0, 1'b0, 32'h20, 4'hF, 32'h11223344};
    vec[9]  = '{32'h43, 32'h0, 32'h9A000000, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 5'd10, 1'b1, 0, 32'h0000009A, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0};
    vec[10] = '{32'h11, 32'h0, 32'h0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 5'd11, 1'b1, 0, 32'h0, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0};
    vec[11] = '{32'h2, 32'h0, 32'h80011234, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 5'd12, 1'b0, 0, 32'h00008001, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0};

    rst = 1'b1;
    drive_nop();
    bus.dmem_rd_data_in = '0;
    bus.dmem_ack_in = 1'b0;
    #3;
    chk("rst_mem_data", mem_data_out, 32'h0);
    chk("rst_alu_data", alu_data_out, 32'h0);
    chk("rst_reg_wen", {31'd0, reg_wr_en_out}, 32'd0);
    chk("rst_misaligned", {31'd0, misaligned_out}, 32'd0);
    chk("rst_bus_en", {30'd0, bus.dmem_rd_en_out, bus.dmem_wr_en_out}, 32'd0);
    chk("rst_bus_addr", bus.dmem_addr_out, 32'h0);
    chk("rst_stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;

    for (int i = 0; i < 12; i++) run(vec[i]);

    // Reset while an access is outstanding, then a stray ack after release.
    alu_data_in = 32'h500; mem_rd_en_in = 1'b1; mem_size_in = 2'b10;
    reg_wr_en_in = 1'b1; reg_wr_addr_in = 5'd13;
    @(posedge clk); #2;
    chk("rst_acc_req_on", {31'd0, bus.dmem_rd_en_out}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_acc_async_drop", {31'd0, bus.dmem_rd_en_out}, 32'd0);
    drive_nop();
    @(posedge clk); #2;
    rst = 1'b0;
    bus.dmem_rd_data_in = 32'hCAFEF00D;
    bus.dmem_ack_in = 1'b1;
    #1;
    chk("late_ack_stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk); #2;
    bus.dmem_ack_in = 1'b0;
    bus.dmem_rd_data_in = '0;
    chk("late_ack_wen", {31'd0, reg_wr_en_out}, 32'd0);
    chk("late_ack_mem_data", mem_data_out, 32'h0);
    chk("late_ack_no_req", {30'd0, bus.dmem_rd_en_out, bus.dmem_wr_en_out}, 32'd0);

    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
